key_debounce_pulse: RTL

KEY_DEBOUNCE_PULSE -- requirements
Module: key_debounce_pulse

---
 rtl/key_debounce_pulse.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/key_debounce_pulse.sv
// Pushbutton debouncer: two-flop synchroniser, press/release debounce FSM and
// hold-to-repeat step generator with one-cycle registered strobes.
module key_debounce_pulse #(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       repeat_en,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       step_pulse,
  output logic [1:0] state
);

  localparam int DW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'b00,
    DEB_PRESS   = 2'b01,
    PRESSED     = 2'b10,
    DEB_RELEASE = 2'b11
  } state_t;

  localparam logic PH_DELAY  = 1'b0;
  localparam logic PH_PERIOD = 1'b1;

  logic          sync1_r;
  logic          sync2_r;
  logic          sync_pressed_s;
  state_t        state_r;
  logic [DW-1:0] deb_cnt_r;
  logic [RW-1:0] rep_cnt_r;
  logic          rep_phase_r;
  logic [RW-1:0] rep_last_s;

  assign sync_pressed_s = ~sync2_r;
  assign rep_last_s     = (rep_phase_r == PH_PERIOD) ? PERIOD_LAST : DELAY_LAST;
  assign state          = state_r;

  // Two-flop synchroniser; idles high so reset looks like a released key.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounce/repeat FSM with all outputs registered; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= RELEASED;
      deb_cnt_r     <= {DW{1'b0}};
      rep_cnt_r     <= {RW{1'b0}};
      rep_phase_r   <= PH_DELAY;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      step_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      step_pulse    <= 1'b0;
      case (state_r)
        RELEASED: begin
          deb_cnt_r <= {DW{1'b0}};
          if (sync_pressed_s) begin
            state_r <= DEB_PRESS;
          end else begin
            state_r <= RELEASED;
          end
        end
        DEB_PRESS: begin
          if (!sync_pressed_s) begin
            state_r   <= RELEASED;
            deb_cnt_r <= {DW{1'b0}};
          end else if (deb_cnt_r == DEB_LAST) begin
            state_r     <= PRESSED;
            deb_cnt_r   <= {DW{1'b0}};
            key_level   <= 1'b1;
            press_pulse <= 1'b1;
            step_pulse  <= 1'b1;
            rep_cnt_r   <= {RW{1'b0}};
            rep_phase_r <= PH_DELAY;
          end else begin
            deb_cnt_r <= deb_cnt_r + 1'b1;
          end
        end
        PRESSED: begin
          // A tick that lands on the release-sample cycle is dropped here.
          if (!sync_pressed_s) begin
            state_r   <= DEB_RELEASE;
            deb_cnt_r <= {DW{1'b0}};
          end else if (!repeat_en) begin
            rep_cnt_r   <= {RW{1'b0}};
            rep_phase_r <= PH_DELAY;
          end else if (rep_cnt_r == rep_last_s) begin
            step_pulse  <= 1'b1;
            rep_cnt_r   <= {RW{1'b0}};
            rep_phase_r <= PH_PERIOD;
          end else begin
            rep_cnt_r <= rep_cnt_r + 1'b1;
          end
        end
        DEB_RELEASE: begin
          if (sync_pressed_s) begin
            state_r   <= PRESSED;
            deb_cnt_r <= {DW{1'b0}};
          end else if (deb_cnt_r == DEB_LAST) begin
            state_r       <= RELEASED;
            deb_cnt_r     <= {DW{1'b0}};
            key_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            deb_cnt_r <= deb_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r     <= RELEASED;
          deb_cnt_r   <= {DW{1'b0}};
          rep_cnt_r   <= {RW{1'b0}};
          rep_phase_r <= PH_DELAY;
          key_level   <= 1'b0;
        end
      endcase
    end
  end

endmodule
